// File: rtl/axi_pkg.sv
// Shared types for the two-port component arbiter: FSM state encoding and
// the idle-time winner selection rule.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } axi_comp_arb_state_e;

    // Winner when the arbiter is free: a lone requester wins, a tie goes to rr.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic rr);
        logic win;
        if (req0 && req1) begin
            win = rr;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/axi_comp_arb_lat_pipe.sv
// Read-valid delay line: carries {valid, src} of each accepted read for
// C_LAT cycles so the pulse lands on the port that issued the read.
module axi_comp_arb_lat_pipe #(
    parameter int C_LAT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic in_src,
    output logic out_vld,
    output logic out_src
);

    generate
        if (C_LAT == 0) begin : g_bypass
            assign out_vld = in_vld;
            assign out_src = in_src;
        end else begin : g_pipe
            logic [C_LAT-1:0] vld_r;
            logic [C_LAT-1:0] src_r;

            // Free-running shift; never stalls so alternating reads stay in order.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= {C_LAT{1'b0}};
                    src_r <= {C_LAT{1'b0}};
                end else begin
                    vld_r[0] <= in_vld;
                    src_r[0] <= in_src;
                    for (int i = 1; i < C_LAT; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        src_r[i] <= src_r[i-1];
                    end
                end
            end

            assign out_vld = vld_r[C_LAT-1];
            assign out_src = src_r[C_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/axi_comp_arb.sv
// Two-port arbiter in front of a single component interface: zero-latency
// round-robin grant in IDLE, burst lock until last, and per-port read-valid return.
module axi_comp_arb
    import axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BC    = DW/8,
    parameter int UW    = 32,
    parameter int IW    = 1,
    parameter int C_LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_dv,
    input  logic [AW-1:0] p0_addr,
    input  logic          p0_write,
    input  logic [UW-1:0] p0_user,
    input  logic [IW-1:0] p0_id,
    input  logic [DW-1:0] p0_wdata,
    input  logic [BC-1:0] p0_wstrb,
    input  logic          p0_last,
    output logic          p0_hld,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_rvld,
    input  logic          p1_dv,
    input  logic [AW-1:0] p1_addr,
    input  logic          p1_write,
    input  logic [UW-1:0] p1_user,
    input  logic [IW-1:0] p1_id,
    input  logic [DW-1:0] p1_wdata,
    input  logic [BC-1:0] p1_wstrb,
    input  logic          p1_last,
    output logic          p1_hld,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_rvld,
    output logic          dv,
    output logic [AW-1:0] addr,
    output logic          write,
    output logic [UW-1:0] user,
    output logic [IW-1:0] id,
    output logic [DW-1:0] wdata,
    output logic [BC-1:0] wstrb,
    output logic          last,
    output logic          src,
    input  logic          hld,
    input  logic          err,
    input  logic [DW-1:0] rdata
);

    axi_comp_arb_state_e state_r;
    axi_comp_arb_state_e state_nxt_s;
    logic                rr_r;
    logic                gnt_s;
    logic                sel_dv_s;
    logic                sel_last_s;
    logic                sel_write_s;
    logic                acc_s;
    logic                pipe_vld_s;
    logic                pipe_src_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round-robin pointer moves only when a burst (or single beat) completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (acc_s && sel_last_s) begin
            rr_r <= ~gnt_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Grant selection, beat acceptance and next state.
    always_comb begin
        case (state_r)
            LOCK0:   gnt_s = 1'b0;
            LOCK1:   gnt_s = 1'b1;
            IDLE:    gnt_s = rr_pick(p0_dv, p1_dv, rr_r);
            default: gnt_s = 1'b0;
        endcase

        // Reset gates dv so the component sees nothing while rst_n is low.
        if (gnt_s) begin
            sel_dv_s    = p1_dv & rst_n;
            sel_last_s  = p1_last;
            sel_write_s = p1_write;
        end else begin
            sel_dv_s    = p0_dv & rst_n;
            sel_last_s  = p0_last;
            sel_write_s = p0_write;
        end
        acc_s = sel_dv_s & ~hld;

        state_nxt_s = state_r;
        if (acc_s) begin
            if (sel_last_s) begin
                state_nxt_s = IDLE;
            end else if (gnt_s) begin
                state_nxt_s = LOCK1;
            end else begin
                state_nxt_s = LOCK0;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    axi_comp_arb_lat_pipe #(
        .C_LAT (C_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (acc_s & ~sel_write_s),
        .in_src  (gnt_s),
        .out_vld (pipe_vld_s),
        .out_src (pipe_src_s)
    );

    // Request routing, per-port stall/error and read return.
    always_comb begin
        dv  = sel_dv_s;
        src = gnt_s;
        if (gnt_s) begin
            addr  = p1_addr;
            write = p1_write;
            user  = p1_user;
            id    = p1_id;
            wdata = p1_wdata;
            wstrb = p1_wstrb;
            last  = p1_last;
        end else begin
            addr  = p0_addr;
            write = p0_write;
            user  = p0_user;
            id    = p0_id;
            wdata = p0_wdata;
            wstrb = p0_wstrb;
            last  = p0_last;
        end

        // The loser is always held; during reset both are held.
        if (!rst_n) begin
            p0_hld = 1'b1;
            p1_hld = 1'b1;
        end else if (gnt_s) begin
            p0_hld = 1'b1;
            p1_hld = hld;
        end else begin
            p0_hld = hld;
            p1_hld = 1'b1;
        end

        p0_err   = acc_s & ~gnt_s & err;
        p1_err   = acc_s &  gnt_s & err;
        p0_rdata = rdata;
        p1_rdata = rdata;
        p0_rvld  = pipe_vld_s & ~pipe_src_s;
        p1_rvld  = pipe_vld_s &  pipe_src_s;
    end

endmodule

// File: tb/tb_axi_comp_arb.sv
// Bench for axi_comp_arb (C_LAT=2): directed scenarios with literal
// expectations, then randomized requesters checked every cycle against a rule model.
module tb_axi_comp_arb;

    localparam int AW = 32, DW = 32, BC = 4, UW = 32, IW = 1, C_LAT = 2;

    logic clk, rst_n;
    logic [1:0] r_dv, r_write, r_last, r_id;
    logic [31:0] r_addr [2];
    logic [31:0] r_user [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];
    logic hld_i, err_i;
    logic [31:0] rdata_i;

    logic p0_hld, p0_err, p0_rvld, p1_hld, p1_err, p1_rvld;
    logic [31:0] p0_rdata, p1_rdata;
    logic dv, write, last, src;
    logic [31:0] addr, user, wdata;
    logic [0:0] id;
    logic [3:0] wstrb;
    logic [1:0] o_hld, o_err;
    assign o_hld = {p1_hld, p0_hld};
    assign o_err = {p1_err, p0_err};

    axi_comp_arb #(.AW(AW), .DW(DW), .BC(BC), .UW(UW), .IW(IW), .C_LAT(C_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_dv(r_dv[0]), .p0_addr(r_addr[0]), .p0_write(r_write[0]), .p0_user(r_user[0]),
        .p0_id(r_id[0:0]), .p0_wdata(r_wdata[0]), .p0_wstrb(r_wstrb[0]), .p0_last(r_last[0]),
        .p0_hld(p0_hld), .p0_err(p0_err), .p0_rdata(p0_rdata), .p0_rvld(p0_rvld),
        .p1_dv(r_dv[1]), .p1_addr(r_addr[1]), .p1_write(r_write[1]), .p1_user(r_user[1]),
        .p1_id(r_id[1:1]), .p1_wdata(r_wdata[1]), .p1_wstrb(r_wstrb[1]), .p1_last(r_last[1]),
        .p1_hld(p1_hld), .p1_err(p1_err), .p1_rdata(p1_rdata), .p1_rvld(p1_rvld),
        .dv(dv), .addr(addr), .write(write), .user(user), .id(id), .wdata(wdata),
        .wstrb(wstrb), .last(last), .src(src),
        .hld(hld_i), .err(err_i), .rdata(rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // Model state: burst owner (-1 = free), round-robin pointer, read-return queue.
    int owner = -1, rr = 0;
    int mp[$];
    int cur_g = 0;
    bit cur_acc = 1'b0;
    int rem [2];
    bit pending [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        owner = -1;
        rr = 0;
        mp = {};
        for (int i = 0; i < C_LAT; i++) mp.push_back(-1);
        cur_acc = 1'b0;
    endtask

    // Compare every DUT output with what the arbitration rules demand this cycle.
    task automatic check_cycle();
        int g;
        bit edv, acc;
        #1;
        if (!rst_n) begin
            clear_model();
            chk("rst_dv", dv, 0);
            chk("rst_p0_rvld", p0_rvld, 0);
            chk("rst_p1_rvld", p1_rvld, 0);
            return;
        end
        if (owner >= 0) g = owner;
        else if (r_dv[0] && r_dv[1]) g = rr;
        else if (r_dv[1]) g = 1;
        else g = 0;
        edv = r_dv[g];
        acc = edv && !hld_i;
        chk("dv", dv, edv);
        if (edv) begin
            chk("src", src, g);
            chk("addr", addr, r_addr[g]);
            chk("write", write, r_write[g]);
            chk("user", user, r_user[g]);
            chk("id", id, r_id[g]);
            chk("wdata", wdata, r_wdata[g]);
            chk("wstrb", wstrb, r_wstrb[g]);
            chk("last", last, r_last[g]);
            chk("gnt_hld", o_hld[g], hld_i);
        end
        if (r_dv[1-g]) chk("loser_hld", o_hld[1-g], 1);
        chk("p0_err", p0_err, acc && g == 0 && err_i);
        chk("p1_err", p1_err, acc && g == 1 && err_i);
        chk("p0_rdata", p0_rdata, rdata_i);
        chk("p1_rdata", p1_rdata, rdata_i);
        chk("p0_rvld", p0_rvld, mp[0] == 0);
        chk("p1_rvld", p1_rvld, mp[0] == 1);
        cur_g = g;
        cur_acc = acc;
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) begin
            if (cur_acc) begin
                if (r_last[cur_g]) begin
                    owner = -1;
                    rr = 1 - cur_g;
                end else begin
                    owner = cur_g;
                end
            end
            mp.push_back((cur_acc && !r_write[cur_g]) ? cur_g : -1);
            void'(mp.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input bit v, input bit wr, input logic [31:0] a, input bit l);
        r_dv[n] = v;
        r_write[n] = wr;
        r_addr[n] = a;
        r_last[n] = l;
        r_user[n] = $urandom;
        r_id[n] = 1'($urandom_range(1));
        r_wdata[n] = $urandom;
        r_wstrb[n] = 4'($urandom_range(15));
    endtask

    task automatic present(input int n);
        r_dv[n] = 1'b1;
        r_last[n] = (rem[n] == 1);
        r_user[n] = $urandom;
        r_id[n] = 1'($urandom_range(1));
        r_wdata[n] = $urandom;
        r_wstrb[n] = 4'($urandom_range(15));
        pending[n] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        hld_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
        for (int n = 0; n < 2; n++) begin
            set_req(n, 1'b1, 1'b0, 32'h0, 1'b1);
            rem[n] = 0;
            pending[n] = 1'b0;
        end
        clear_model();
        @(negedge clk);
        // Reset with both ports requesting: component must see dv=0.
        repeat (3) begin
            check_cycle();
            chk("lit_rst_dv", dv, 1'b0);
            adv();
        end
        r_dv = 2'b00;
        rst_n = 1'b1;
        check_cycle();
        adv();

        // Contention after reset: p0 first, then p1.
        set_req(0, 1'b1, 1'b1, 32'h100, 1'b1);
        set_req(1, 1'b1, 1'b1, 32'h200, 1'b1);
        check_cycle();
        chk("lit_cont_src0", src, 1'b0);
        chk("lit_cont_p1_hld", p1_hld, 1'b1);
        adv();
        r_dv[0] = 1'b0;
        check_cycle();
        chk("lit_cont_src1", src, 1'b1);
        adv();
        r_dv[1] = 1'b0;

        // Single p1 read at 0x40; valid returns C_LAT cycles later on p1 only.
        set_req(1, 1'b1, 1'b0, 32'h40, 1'b1);
        check_cycle();
        chk("lit_single_dv", dv, 1'b1);
        chk("lit_single_src", src, 1'b1);
        chk("lit_single_addr", addr, 32'h40);
        adv();
        r_dv[1] = 1'b0;
        check_cycle();
        chk("lit_single_early", p1_rvld, 1'b0);
        adv();
        check_cycle();
        chk("lit_single_p1_rvld", p1_rvld, 1'b1);
        chk("lit_single_p0_rvld", p0_rvld, 1'b0);
        adv();

        // p0 4-beat write burst holds the lock against a waiting p1.
        set_req(1, 1'b1, 1'b1, 32'h300, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_req(0, 1'b1, 1'b1, 32'h1000 + 32'(4*b), b == 3);
            check_cycle();
            chk("lit_burst_src", src, 1'b0);
            chk("lit_burst_p1_hld", p1_hld, 1'b1);
            adv();
        end
        r_dv[0] = 1'b0;
        check_cycle();
        chk("lit_burst_after_src", src, 1'b1);
        chk("lit_burst_after_dv", dv, 1'b1);
        adv();
        r_dv[1] = 1'b0;

        // p1 burst stalled by the component for 3 cycles with p0 waiting.
        set_req(1, 1'b1, 1'b0, 32'h500, 1'b0);
        check_cycle();
        adv();
        set_req(1, 1'b1, 1'b0, 32'h504, 1'b1);
        set_req(0, 1'b1, 1'b1, 32'h600, 1'b1);
        hld_i = 1'b1;
        repeat (3) begin
            check_cycle();
            chk("lit_stall_p1_hld", p1_hld, 1'b1);
            chk("lit_stall_p0_hld", p0_hld, 1'b1);
            chk("lit_stall_dv", dv, 1'b1);
            chk("lit_stall_addr", addr, 32'h504);
            adv();
        end
        hld_i = 1'b0;
        check_cycle();
        adv();
        r_dv[1] = 1'b0;

        // p0 now served; component flags an error on this beat.
        err_i = 1'b1;
        check_cycle();
        chk("lit_err_p0", p0_err, 1'b1);
        chk("lit_err_p1", p1_err, 1'b0);
        adv();
        err_i = 1'b0;
        r_dv[0] = 1'b0;

        // p1 4-beat read, reset after beat 2.
        for (int b = 0; b < 2; b++) begin
            set_req(1, 1'b1, 1'b0, 32'h800 + 32'(4*b), 1'b0);
            check_cycle();
            adv();
        end
        set_req(1, 1'b1, 1'b0, 32'h808, 1'b0);
        rst_n = 1'b0;
        check_cycle();
        chk("lit_mrst_dv", dv, 1'b0);
        adv();
        check_cycle();
        adv();
        r_dv = 2'b00;
        rst_n = 1'b1;
        repeat (4) begin
            check_cycle();
            chk("lit_mrst_p0_rvld", p0_rvld, 1'b0);
            chk("lit_mrst_p1_rvld", p1_rvld, 1'b0);
            adv();
        end
        set_req(0, 1'b1, 1'b1, 32'h900, 1'b1);
        set_req(1, 1'b1, 1'b1, 32'hA00, 1'b1);
        check_cycle();
        chk("lit_mrst_rr", src, 1'b0);
        adv();
        r_dv = 2'b00;
        check_cycle();
        adv();

        // Randomized requesters obeying the hold-stable handshake.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            hld_i = ($urandom_range(3) == 0);
            err_i = ($urandom_range(7) == 0);
            rdata_i = $urandom;
            check_cycle();
            adv();
            if (cur_acc) begin
                pending[cur_g] = 1'b0;
                rem[cur_g] = rem[cur_g] - 1;
                r_addr[cur_g] = r_addr[cur_g] + 32'd4;
            end
            for (int n = 0; n < 2; n++) begin
                if (!pending[n]) begin
                    if (rem[n] > 0) begin
                        if ($urandom_range(3) != 0) present(n);
                        else r_dv[n] = 1'b0;
                    end else if ($urandom_range(1) == 1) begin
                        rem[n] = $urandom_range(1, 4);
                        r_write[n] = 1'($urandom_range(1));
                        r_addr[n] = $urandom & 32'hFFFF_FFFC;
                        present(n);
                    end else begin
                        r_dv[n] = 1'b0;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
